emulib_rammodel_responder: RTL

Return-path endpoint of the RAM model. The timing/backing model pushes write completions and read-data beats into this block, and the block drives them as AXI4 B and R responses toward the emulated master. It is the counterpart of the request tracker, which turns AXI AW/W/AR traffic into areq/wreq streams and unconditionally sinks B/R. Contents:
- separate B and R FIFOs, one per channel;
- an R-burst framer that generates rlast from the burst length.

---
 rtl/emulib_rammodel_responder_if.sv | 55 +++++
 rtl/emulib_rammodel_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/emulib_rammodel_responder_if.sv
// emulib_rammodel_responder_if
// Bundles the backend push streams (B completions, R beats) and the AXI B/R
// response channels of the RAM-model responder.
// The slave modport is the responder's view; the master modport is the
// environment's view (backend plus emulated AXI master).
// Optional macro RAMMODEL_RESPONDER_ERR_EN adds the per-entry error inputs.
interface emulib_rammodel_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) ();
    logic                  bresp_valid;
    logic                  bresp_ready;
    logic [ID_WIDTH-1:0]   bresp_id;
    logic                  rresp_valid;
    logic                  rresp_ready;
    logic [ID_WIDTH-1:0]   rresp_id;
    logic [7:0]            rresp_len;
    logic [DATA_WIDTH-1:0] rresp_data;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [ID_WIDTH-1:0]   axi_bid;
    logic [1:0]            axi_bresp;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [ID_WIDTH-1:0]   axi_rid;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
`ifdef RAMMODEL_RESPONDER_ERR_EN
    logic                  bresp_err;
    logic                  rresp_err;
`endif

    modport slave (
`ifdef RAMMODEL_RESPONDER_ERR_EN
        input  bresp_err, rresp_err,
`endif
        input  bresp_valid, bresp_id, rresp_valid, rresp_id, rresp_len, rresp_data,
        input  axi_bready, axi_rready,
        output bresp_ready, rresp_ready,
        output axi_bvalid, axi_bid, axi_bresp,
        output axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );

    modport master (
`ifdef RAMMODEL_RESPONDER_ERR_EN
        output bresp_err, rresp_err,
`endif
        output bresp_valid, bresp_id, rresp_valid, rresp_id, rresp_len, rresp_data,
        output axi_bready, axi_rready,
        input  bresp_ready, rresp_ready,
        input  axi_bvalid, axi_bid, axi_bresp,
        input  axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );
endinterface

// File: rtl/emulib_rammodel_responder.sv
// emulib_rammodel_responder
// Return-path endpoint of the RAM model: buffers backend write completions
// and read beats in two independent first-word-fall-through FIFOs and presents
// them as AXI4 B and R responses. An R framer stamps the burst ID and derives
// rlast from the AXI len sampled on the first beat of each burst.
// Optional macro RAMMODEL_RESPONDER_ERR_EN adds per-entry error flags that
// turn the response code into SLVERR; without it responses are always OKAY.
module emulib_rammodel_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int B_FIFO_DEPTH = 8,
    parameter int R_FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    emulib_rammodel_responder_if.slave   bus,
    output logic                         idle
);

    localparam int BAW = $clog2(B_FIFO_DEPTH);
    localparam int BCW = BAW + 1;
    localparam int RAW = $clog2(R_FIFO_DEPTH);
    localparam int RCW = RAW + 1;
    localparam logic [BCW-1:0] B_FULL_CNT = BCW'(B_FIFO_DEPTH);
    localparam logic [RCW-1:0] R_FULL_CNT = RCW'(R_FIFO_DEPTH);

    typedef enum logic {
        R_HEAD,
        R_BODY
    } rState_e;

    // ------------------------------------------------------------------
    // B channel FIFO
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] bIdMem_q [B_FIFO_DEPTH];
    logic [BAW-1:0]      bWrPtr_q, bWrPtr_d;
    logic [BAW-1:0]      bRdPtr_q, bRdPtr_d;
    logic [BCW-1:0]      bCount_q, bCount_d;
    logic                bFull, bEmpty, bPush, bPop;

    assign bFull  = (bCount_q == B_FULL_CNT);
    assign bEmpty = (bCount_q == '0);
    assign bPush  = bus.bresp_valid && !bFull;
    assign bPop   = !bEmpty && bus.axi_bready;

    assign bus.bresp_ready = !bFull;
    assign bus.axi_bvalid  = !bEmpty;
    assign bus.axi_bid     = bEmpty ? '0 : bIdMem_q[bRdPtr_q];

    // Next-state pointers and occupancy; push+pop together keeps the count
    always_comb begin
        bWrPtr_d = bWrPtr_q;
        bRdPtr_d = bRdPtr_q;
        bCount_d = bCount_q;
        if (bPush) begin
            bWrPtr_d = bWrPtr_q + BAW'(1);
        end
        if (bPop) begin
            bRdPtr_d = bRdPtr_q + BAW'(1);
        end
        if (bPush && !bPop) begin
            bCount_d = bCount_q + BCW'(1);
        end else if (!bPush && bPop) begin
            bCount_d = bCount_q - BCW'(1);
        end
    end

    // B pointer/count registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bWrPtr_q <= '0;
            bRdPtr_q <= '0;
            bCount_q <= '0;
        end else begin
            bWrPtr_q <= bWrPtr_d;
            bRdPtr_q <= bRdPtr_d;
            bCount_q <= bCount_d;
        end
    end

    // B storage; contents are only visible while the entry is counted
    always_ff @(posedge clk) begin
        if (bPush) begin
            bIdMem_q[bWrPtr_q] <= bus.bresp_id;
        end
    end

    // ------------------------------------------------------------------
    // R burst framer
    // ------------------------------------------------------------------
    rState_e             rState_q;
    logic [7:0]          rRemain_q;
    logic [ID_WIDTH-1:0] rCurId_q;
    logic [ID_WIDTH-1:0] rPushId;
    logic                rPushLast;

    // ------------------------------------------------------------------
    // R channel FIFO
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]   rIdMem_q   [R_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rDataMem_q [R_FIFO_DEPTH];
    logic                  rLastMem_q [R_FIFO_DEPTH];
    logic [RAW-1:0]        rWrPtr_q, rWrPtr_d;
    logic [RAW-1:0]        rRdPtr_q, rRdPtr_d;
    logic [RCW-1:0]        rCount_q, rCount_d;
    logic                  rFull, rEmpty, rPush, rPop;

    assign rFull  = (rCount_q == R_FULL_CNT);
    assign rEmpty = (rCount_q == '0);
    assign rPush  = bus.rresp_valid && !rFull;
    assign rPop   = !rEmpty && bus.axi_rready;

    assign bus.rresp_ready = !rFull;
    assign bus.axi_rvalid  = !rEmpty;
    assign bus.axi_rid     = rEmpty ? '0   : rIdMem_q[rRdPtr_q];
    assign bus.axi_rdata   = rEmpty ? '0   : rDataMem_q[rRdPtr_q];
    assign bus.axi_rlast   = rEmpty ? 1'b0 : rLastMem_q[rRdPtr_q];

    // Beat tagging: the header beat carries its own id/len, body beats reuse
    // the latched id and count down to the final beat
    always_comb begin
        rPushId   = rCurId_q;
        rPushLast = (rRemain_q == 8'd1);
        if (rState_q == R_HEAD) begin
            rPushId   = bus.rresp_id;
            rPushLast = (bus.rresp_len == 8'd0);
        end
    end

    // Framer FSM: advances only on an accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q  <= R_HEAD;
            rRemain_q <= 8'd0;
            rCurId_q  <= '0;
        end else if (rPush) begin
            case (rState_q)
                R_HEAD: begin
                    rCurId_q <= bus.rresp_id;
                    if (bus.rresp_len != 8'd0) begin
                        rRemain_q <= bus.rresp_len;
                        rState_q  <= R_BODY;
                    end
                end
                R_BODY: begin
                    rRemain_q <= rRemain_q - 8'd1;
                    if (rRemain_q == 8'd1) begin
                        rState_q <= R_HEAD;
                    end
                end
                default: begin
                    rState_q <= R_HEAD;
                end
            endcase
        end
    end

    // Next-state pointers and occupancy for the R FIFO
    always_comb begin
        rWrPtr_d = rWrPtr_q;
        rRdPtr_d = rRdPtr_q;
        rCount_d = rCount_q;
        if (rPush) begin
            rWrPtr_d = rWrPtr_q + RAW'(1);
        end
        if (rPop) begin
            rRdPtr_d = rRdPtr_q + RAW'(1);
        end
        if (rPush && !rPop) begin
            rCount_d = rCount_q + RCW'(1);
        end else if (!rPush && rPop) begin
            rCount_d = rCount_q - RCW'(1);
        end
    end

    // R pointer/count registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rWrPtr_q <= '0;
            rRdPtr_q <= '0;
            rCount_q <= '0;
        end else begin
            rWrPtr_q <= rWrPtr_d;
            rRdPtr_q <= rRdPtr_d;
            rCount_q <= rCount_d;
        end
    end

    // R storage written with the framed beat
    always_ff @(posedge clk) begin
        if (rPush) begin
            rIdMem_q[rWrPtr_q]   <= rPushId;
            rDataMem_q[rWrPtr_q] <= bus.rresp_data;
            rLastMem_q[rWrPtr_q] <= rPushLast;
        end
    end

    // ------------------------------------------------------------------
    // Response codes
    // ------------------------------------------------------------------
`ifdef RAMMODEL_RESPONDER_ERR_EN
    logic bErrMem_q [B_FIFO_DEPTH];
    logic rErrMem_q [R_FIFO_DEPTH];

    // Per-entry error flags travel alongside the B and R payloads
    always_ff @(posedge clk) begin
        if (bPush) begin
            bErrMem_q[bWrPtr_q] <= bus.bresp_err;
        end
        if (rPush) begin
            rErrMem_q[rWrPtr_q] <= bus.rresp_err;
        end
    end

    assign bus.axi_bresp = (!bEmpty && bErrMem_q[bRdPtr_q]) ? 2'b10 : 2'b00;
    assign bus.axi_rresp = (!rEmpty && rErrMem_q[rRdPtr_q]) ? 2'b10 : 2'b00;
`else
    assign bus.axi_bresp = 2'b00;
    assign bus.axi_rresp = 2'b00;
`endif

    assign idle = bEmpty && rEmpty && (rState_q == R_HEAD);

endmodule
